muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide functional unit in the EX stage.
- Produces the `busy`/`done` pair that the pipeline hazard logic consumes as its functional-unit-busy stall source.
- Uses radix-2 shift-add for multiply and restoring division for divide, one iteration per clock.
- The result is returned to the EX-stage result mux when `done` pulses.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  EX-stage M-extension instruction valid; request operation.
- kill  input  1  abort in-flight operation (pipeline flush).
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (after forwarding).
- op_b  input  XLEN  rs2 value (after forwarding).
- result  output  XLEN  operation result, valid when done=1.
- busy  output  1  unit occupied; pipeline must stall.
- done  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; result=0, busy=0, done=0.
  - Counter and internal registers cleared.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and kill=0: latch funct3 and operands; compute absolute values per signedness.
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - U variants: both operands unsigned.
  - Record the result sign:
    - Product/quotient sign = sign_a XOR sign_b.
    - Remainder sign = sign_a.
  - Special cases go IDLE->DONE directly (fast path):
    - Divide by zero (op_b=0): quotient = 0xFFFFFFFF, remainder = op_a.
    - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Otherwise go IDLE->CALC with counter=0.
- busy (combinational):
  - busy = (start & ~kill & state==IDLE) | (state==CALC).
  - Busy is high in the start cycle so the instruction holds in EX.
  - Busy is low in the DONE cycle so the pipeline advances with the result.
- CALC:
  - One iteration per cycle, XLEN iterations; counter increments each cycle.
  - Multiply: 64-bit accumulator; if multiplier LSB=1, add the shifted multiplicand; shift.
  - Divide: shift the remainder left, bring in the next dividend MSB, trial-subtract the divisor; if non-negative, keep it and set the quotient bit.
  - At counter==XLEN-1: apply sign fix (two's complement negate if the sign flag is set), select the output, go to DONE.
    - MUL: low word of the product.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
- Latency:
  - Start accepted in cycle 0; CALC occupies cycles 1..32; DONE at cycle 33.
  - Fast path: DONE at cycle 1.
- DONE:
  - done=1 for exactly one cycle, result registered and valid; return to IDLE.
  - result holds its value until the next DONE.
  - start in the DONE cycle is ignored; the requester re-presents it next cycle.
- start while in CALC: ignored; the operands latched at acceptance are used.
- kill:
  - Any state -> IDLE next cycle; done is not pulsed; result keeps its old value.
  - kill together with start in IDLE: start is not accepted, busy=0.
- Operands are not re-sampled after acceptance; forwarding changes during CALC have no effect.
- Arithmetic width rules:
  - Accumulator is 2*XLEN bits; remainder register is XLEN+1 bits to hold the trial-subtract sign.
  - All negation is modulo 2^XLEN.

Test Plan:
- MUL 7 × -3 (op_a=0x00000007, op_b=0xFFFFFFFD, funct3=000) -> busy high cycles 0..32, done at cycle 33, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE.
- MULH same operands -> result=0x00000000.
- MULHSU op_a=0xFFFFFFFF, op_b=0x00000002 -> result=0xFFFFFFFF.
- DIV -7/2 -> result=0xFFFFFFFD (-3).
- REM -7/2 -> result=0xFFFFFFFF (-1).
- DIVU 100/7 -> result=14.
- REMU 100/7 -> result=2.
- Fast path, DIV 5/0 -> done at cycle 1, result=0xFFFFFFFF.
- Fast path, REMU 5/0 -> result=5.
- Fast path, DIV 0x80000000/-1 -> result=0x80000000.
- Fast path, REM same operands -> result=0.
- Abort: start DIVU, assert kill at cycle 10 -> IDLE at cycle 11, no done pulse, busy=0, result unchanged. A following start runs a full 33-cycle operation correctly.
- Async reset: assert rst at cycle 15 of a MUL, between clock edges -> busy/done/result go to 0 immediately. start after release -> normal operation.
- Back-to-back: start held high continuously -> second operation accepted in the cycle after DONE. Exactly one done pulse per operation; start during CALC/DONE produces no extra done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
// Operands are converted to magnitudes at acceptance; the sign is re-applied
// on the final iteration. Divide-by-zero and signed overflow take a one-cycle
// fast path that skips the iteration loop.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two's complement negate, modulo 2^XLEN.
    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negate of a full double-width product.
    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          op_r;
    logic                neg_q_r;     // sign of product / quotient
    logic                neg_rem_r;   // sign of remainder (follows dividend)
    logic [XLEN-1:0]     mcand_r;
    logic [2*XLEN-1:0]   acc_r;       // {partial high word, remaining multiplier}
    logic [XLEN-1:0]     divisor_r;
    logic [XLEN-1:0]     rem_r;       // kept remainder; the trial value below is XLEN+1 bits
    logic [XLEN-1:0]     quo_r;       // dividend shifts out the top, quotient shifts in

    logic                accept_s;
    logic                signed_a_s, signed_b_s;
    logic                a_neg_s, b_neg_s;
    logic [XLEN-1:0]     abs_a_s, abs_b_s;
    logic                div_zero_s, div_ovf_s, fast_s;
    logic [XLEN-1:0]     fast_res_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   acc_nxt_s;
    logic [XLEN:0]       div_shift_s, div_trial_s;
    logic [XLEN-1:0]     rem_nxt_s, quo_nxt_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s, calc_res_s;
    logic                last_s;

    assign accept_s = start & ~kill & (state_r == IDLE);
    assign last_s   = (cnt_r == LAST_CNT);

    // Operand signedness, magnitudes and fast-path detection at acceptance.
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            3'b010: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        a_neg_s    = signed_a_s & op_a[XLEN-1];
        b_neg_s    = signed_b_s & op_b[XLEN-1];
        abs_a_s    = a_neg_s ? neg_w(op_a) : op_a;
        abs_b_s    = b_neg_s ? neg_w(op_b) : op_b;
        div_zero_s = funct3[2] & (op_b == {XLEN{1'b0}});
        div_ovf_s  = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
        fast_s     = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            fast_res_s = funct3[1] ? op_a : ALL_ONES;
        end else begin
            fast_res_s = funct3[1] ? {XLEN{1'b0}} : MIN_NEG;
        end
    end

    // One multiply step and one restoring-divide step on the held magnitudes.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        acc_nxt_s   = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shift_s = {rem_r, quo_r[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, divisor_r};
        if (div_trial_s[XLEN]) begin
            rem_nxt_s = div_shift_s[XLEN-1:0];
        end else begin
            rem_nxt_s = div_trial_s[XLEN-1:0];
        end
        quo_nxt_s   = {quo_r[XLEN-2:0], ~div_trial_s[XLEN]};
    end

    // Sign fix and output select applied to the final iteration's values.
    always_comb begin
        prod_fix_s = neg_q_r   ? neg_d(acc_nxt_s) : acc_nxt_s;
        quo_fix_s  = neg_q_r   ? neg_w(quo_nxt_s) : quo_nxt_s;
        rem_fix_s  = neg_rem_r ? neg_w(rem_nxt_s) : rem_nxt_s;
        case (op_r)
            3'b000:                 calc_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res_s = quo_fix_s;
            3'b110, 3'b111:         calc_res_s = rem_fix_s;
            default:                calc_res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; kill always returns to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = fast_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_nxt_s = IDLE;
                end else if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: busy stalls the pipeline in the start cycle and during CALC.
    always_comb begin
        busy = ~rst & (accept_s | (state_r == CALC));
        done = (state_r == DONE);
    end

    // Operand capture at acceptance and per-cycle iteration in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= 3'b000;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            mcand_r   <= {XLEN{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            divisor_r <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
        end else if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= funct3;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            mcand_r   <= abs_a_s;
            acc_r     <= {{XLEN{1'b0}}, abs_b_s};
            divisor_r <= abs_b_s;
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= abs_a_s;
        end else if (state_r == CALC) begin
            cnt_r     <= cnt_r + CNT_ONE;
            acc_r     <= acc_nxt_s;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
        end
    end

    // Result register: updated only on the way into DONE, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= {XLEN{1'b0}};
        end else if (accept_s && fast_s) begin
            result <= fast_res_s;
        end else if ((state_r == CALC) && last_s && !kill) begin
            result <= calc_res_s;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases with literal
// expectations, kill/reset/back-to-back scenarios, then random traffic.
// A transaction-level model predicts busy/done/result every cycle.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RV32M reference computed with plain wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] a32, b32, q32;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        a32 = a;
        b32 = b;
        ovf = (a == MIN_NEG) && (b == ALL_ONES);
        ref_result = 32'd0;
        case (f)
            3'd0: begin p = sa * sb; ref_result = p[31:0];  end
            3'd1: begin p = sa * sb; ref_result = p[63:32]; end
            3'd2: begin p = sa * ub; ref_result = p[63:32]; end
            3'd3: begin p = ua * ub; ref_result = p[63:32]; end
            3'd4: begin
                if (b == 32'd0)  ref_result = ALL_ONES;
                else if (ovf)    ref_result = MIN_NEG;
                else begin q32 = a32 / b32; ref_result = q32; end
            end
            3'd5: ref_result = (b == 32'd0) ? ALL_ONES : a / b;
            3'd6: begin
                if (b == 32'd0)  ref_result = a;
                else if (ovf)    ref_result = 32'd0;
                else begin q32 = a32 % b32; ref_result = q32; end
            end
            default: ref_result = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == MIN_NEG && b == ALL_ONES));
    endfunction

    // Transaction model: an accepted op yields done one edge later (fast
    // path) or 33 edges later, unless killed; start is ignored while busy
    // or in the done cycle.
    logic        m_inflight;
    logic        m_done;
    int          m_left;
    logic [31:0] m_pend;
    logic [31:0] m_res;

    // Model update on each clock edge, cleared by async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_done     <= 1'b0;
            m_left     <= 0;
            m_pend     <= 32'd0;
            m_res      <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_inflight) begin
                if (kill) begin
                    m_inflight <= 1'b0;
                end else if (m_left == 1) begin
                    m_inflight <= 1'b0;
                    m_done     <= 1'b1;
                    m_res      <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !kill && !m_done) begin
                m_pend <= ref_result(funct3, op_a, op_b);
                if (is_fast(funct3, op_a, op_b)) begin
                    m_done <= 1'b1;
                    m_res  <= ref_result(funct3, op_a, op_b);
                end else begin
                    m_inflight <= 1'b1;
                    m_left     <= 32;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        check("busy", {31'd0, busy},
              {31'd0, !rst && (m_inflight || (start && !kill && !m_done))});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("result", result, m_res);
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return ALL_ONES;
            2:       return MIN_NEG;
            3:       return $urandom_range(0, 20);
            4:       return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble operands after acceptance, check latency and result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string nm);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check({"lat_", nm}, lat, exp_lat);
        check({"res_", nm}, result, exp);
    endtask

    initial begin
        int n_done;
        logic [31:0] held;
        rst = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);

        // Directed cases with hand-computed results.
        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run_op(3'b011, ALL_ONES, ALL_ONES, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(3'b001, ALL_ONES, ALL_ONES, 32'h0000_0000, 33, "mulh");
        run_op(3'b010, ALL_ONES, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
        run_op(3'b100, 32'd5, 32'd0, ALL_ONES, 1, "div0");
        run_op(3'b100, MIN_NEG, ALL_ONES, MIN_NEG, 1, "div_ovf");
        run_op(3'b110, MIN_NEG, ALL_ONES, 32'd0, 1, "rem_ovf");
        run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu0");

        // Abort: kill in cycle 10 of a DIVU.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'd0, busy}, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("kill_no_done", n_done, 0);
        check("kill_result_held", result, 32'd5);
        run_op(3'b101, 32'd1000, 32'd3, 32'd333, 33, "after_kill");

        // Async reset mid-MUL, between clock edges.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd12345; op_b = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        run_op(3'b000, 32'd12345, 32'd678, 32'd8369910, 33, "after_rst");

        // Back-to-back with start held: two ops over cycles 0..67.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b011; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        held = result;
        n_done = 0;
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("b2b_done_count", n_done, 2);
        check("b2b_result", result, 32'h0B00_EA4E);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start  = ($urandom_range(0, 9) < 7);
            kill   = ($urandom_range(0, 99) < 1);
            funct3 = 3'($urandom);
            op_a   = pick_operand();
            op_b   = pick_operand();
        end
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
